// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks.
//   SEG_BLANK     : all segments off (active low)
//   AN_OFF        : all digit enables off (active low)
//   HEX_SEG_TABLE : active-low g..a patterns for hex digits 0-F
//   state_e       : arbiter states
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Bit 6 is segment g, bit 0 is segment a; a 0 lights the segment.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble_i : 4-bit value to display (0-F)
//   seg_o    : segments g..a, active low
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares a 4-digit common-anode seven-segment display among up to
// four debug requesters. A clock-enable divider scans the digits; at each
// frame boundary the owner is re-evaluated round-robin and its data word is
// snapshotted so a frame never mixes sources or data values.
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous, active-high reset
//   req_i      : per-source display request (level)
//   lock_i     : keep the current owner while it keeps requesting
//   src_data_i : four hex nibbles per source, nibble 0 on the rightmost digit
//   seg_o      : segments g..a, active low
//   dp_o       : decimal point, active low, lit on the digit matching cur_src_o
//   an_o       : digit enables, active low
//   grant_o    : one-hot owner, zero when idle
//   cur_src_o  : owner index, holds its last value when idle
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int DWELL_FRAMES = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_SRC-1:0]     req_i,
    input  logic                 lock_i,
    input  logic [16*N_SRC-1:0]  src_data_i,
    output logic [6:0]           seg_o,
    output logic                 dp_o,
    output logic [3:0]           an_o,
    output logic [N_SRC-1:0]     grant_o,
    output logic [1:0]           cur_src_o
);

    localparam int DIV_W   = $clog2(REFRESH_DIV);
    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    // Lowest-index requester at or after cur+1, wrapping modulo N_SRC.
    // Scanning from the farthest offset down lets the nearest one win;
    // offset N_SRC is the current owner itself, so it is re-granted only
    // when no other source requests.
    function automatic logic [1:0] rr_pick(input logic [N_SRC-1:0] req,
                                           input logic [1:0]       cur);
        logic [1:0] pick;
        pick = cur;
        for (int off = N_SRC; off >= 1; off--) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (i == (int'(cur) + off) % N_SRC && req[i]) begin
                    pick = 2'(i);
                end
            end
        end
        return pick;
    endfunction

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [1:0]         digit_sel_q, digit_sel_d;
    state_e             state_q,     state_d;
    logic [1:0]         cur_src_q,   cur_src_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [15:0]        snap_q,      snap_d;
    logic [N_SRC-1:0]   grant_q,     grant_d;
    logic [6:0]         seg_q,       seg_d;
    logic [3:0]         an_q,        an_d;
    logic               dp_q,        dp_d;

    logic               slot_tick;
    logic               frame_tick;
    logic               owner_req;
    logic               dwell_done;
    logic [3:0]         nibble_d;
    logic [6:0]         nibble_seg;

    // Decodes the digit that becomes visible on the next slot edge.
    hex_to_7seg u_hex_to_7seg (
        .nibble_i (nibble_d),
        .seg_o    (nibble_seg)
    );

    assign slot_tick  = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    assign frame_tick = slot_tick && (digit_sel_q == 2'd3);
    assign dwell_done = (dwell_cnt_q == DWELL_W'(DWELL_FRAMES - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        div_cnt_d   = slot_tick ? '0 : div_cnt_q + 1'b1;
        digit_sel_d = slot_tick ? digit_sel_q + 2'd1 : digit_sel_q;
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        dwell_cnt_d = dwell_cnt_q;
        snap_d      = snap_q;
        grant_d     = '0;
        seg_d       = seg_q;
        an_d        = an_q;
        dp_d        = dp_q;
        owner_req   = 1'b0;

        for (int i = 0; i < N_SRC; i++) begin
            if (cur_src_q == 2'(i)) owner_req = req_i[i];
        end

        if (frame_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_d     = SHOW;
                        cur_src_d   = rr_pick(req_i, cur_src_q);
                        dwell_cnt_d = '0;
                    end
                end
                SHOW: begin
                    if (lock_i && owner_req) begin
                        // Locked owner keeps the display; dwell is frozen.
                        dwell_cnt_d = dwell_cnt_q;
                    end else if (!owner_req || dwell_done) begin
                        dwell_cnt_d = '0;
                        if (|req_i) begin
                            cur_src_d = rr_pick(req_i, cur_src_q);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Snapshot the owner's word once per frame so the digits of a
            // frame always come from one consistent value.
            if (state_d == SHOW) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (cur_src_d == 2'(i)) snap_d = src_data_i[16*i +: 16];
                end
            end
        end

        for (int i = 0; i < N_SRC; i++) begin
            grant_d[i] = (state_d == SHOW) && (cur_src_d == 2'(i));
        end

        nibble_d = snap_d[{digit_sel_d, 2'b00} +: 4];

        // Display pins are computed from next-state values so that the
        // frame_tick edge already shows digit 0 of the new owner.
        if (slot_tick) begin
            if (state_d == SHOW) begin
                an_d  = ~(4'b0001 << digit_sel_d);
                seg_d = nibble_seg;
                dp_d  = (digit_sel_d != cur_src_d);
            end else begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            div_cnt_q   <= '0;
            digit_sel_q <= 2'd0;
            state_q     <= IDLE;
            cur_src_q   <= 2'd0;
            dwell_cnt_q <= '0;
            snap_q      <= 16'h0000;
            grant_q     <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_OFF;
            dp_q        <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_sel_q <= digit_sel_d;
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            dwell_cnt_q <= dwell_cnt_d;
            snap_q      <= snap_d;
            grant_q     <= grant_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
        end
    end

    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign an_o      = an_q;
    assign grant_o   = grant_q;
    assign cur_src_o = cur_src_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with N_SRC=4, REFRESH_DIV=4,
// DWELL_FRAMES=2 (one digit slot = 4 cycles, one frame = 16 cycles).
// Expected per-slot display records are queued when stimulus is driven and
// compared by a monitor at every slot boundary.
module tb_seg_display_arbiter;

    localparam int N_SRC        = 4;
    localparam int REFRESH_DIV  = 4;
    localparam int DWELL_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        lock;
    logic [63:0] src_data;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [3:0]  grant;
    logic [1:0]  cur_src;

    seg_display_arbiter #(
        .N_SRC        (N_SRC),
        .REFRESH_DIV  (REFRESH_DIV),
        .DWELL_FRAMES (DWELL_FRAMES)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .lock_i     (lock),
        .src_data_i (src_data),
        .seg_o      (seg),
        .dp_o       (dp),
        .an_o       (an),
        .grant_o    (grant),
        .cur_src_o  (cur_src)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; frame boundaries sit at multiples of 16.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] grant;
        logic [1:0] cur;
    } slot_t;

    typedef struct {
        logic [3:0]  req;
        logic        lock;
        logic [63:0] data;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_cur;
        logic [15:0] exp_data;
    } vec_t;

    slot_t sb[$];
    vec_t  vecs[18];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en    = 1'b0;
    int mon_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic push_idle(input logic [1:0] cur);
        slot_t r;
        r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1; r.grant = 4'h0; r.cur = cur;
        sb.push_back(r);
    endtask

    task automatic push_show(input logic [3:0] g, input logic [1:0] cur, input logic [15:0] data);
        slot_t r;
        for (int k = 0; k < 4; k++) begin
            r.an    = ~(4'b0001 << k);
            r.seg   = ref_seg(data[4*k +: 4]);
            r.dp    = (k == int'(cur)) ? 1'b0 : 1'b1;
            r.grant = g;
            r.cur   = cur;
            sb.push_back(r);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                $display("FAIL wait_cyc: cycle %0d never reached (now %0d)", n, cyc);
                $fatal(1, "wait bound expired");
            end
        end
    endtask

    // Scoreboard monitor: one queued record per digit slot.
    always @(negedge clk) begin : monitor
        slot_t e;
        if (mon_en && cyc >= mon_start && cyc % 4 == 0) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: no expected slot queued at cycle %0d, got an=0x%0h", cyc, an);
            end else begin
                e = sb.pop_front();
                check("an",      32'(an),      32'(e.an));
                check("seg",     32'(seg),     32'(e.seg));
                check("dp",      32'(dp),      32'(e.dp));
                check("grant",   32'(grant),   32'(e.grant));
                check("cur_src", 32'(cur_src), 32'(e.cur));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] d;
        d = {16'h89EF, 16'hA5C3, 16'h4567, 16'h0123};

        // Frame-by-frame expectations; inputs are applied mid-way through
        // the preceding frame so they are stable at the frame boundary.
        vecs[0]  = '{4'b0100, 1'b0, d, 4'b0100, 2'd2, 16'hA5C3};
        vecs[1]  = '{4'b0100, 1'b0, d, 4'b0100, 2'd2, 16'hA5C3};
        vecs[2]  = '{4'b0100, 1'b0, d, 4'b0100, 2'd2, 16'hA5C3};
        vecs[3]  = '{4'b0100, 1'b0, d, 4'b0100, 2'd2, 16'hA5C3};
        vecs[4]  = '{4'b1011, 1'b0, d, 4'b1000, 2'd3, 16'h89EF};
        vecs[5]  = '{4'b1011, 1'b0, d, 4'b1000, 2'd3, 16'h89EF};
        vecs[6]  = '{4'b1011, 1'b0, d, 4'b0001, 2'd0, 16'h0123};
        vecs[7]  = '{4'b1011, 1'b0, d, 4'b0001, 2'd0, 16'h0123};
        vecs[8]  = '{4'b1011, 1'b0, d, 4'b0010, 2'd1, 16'h4567};
        vecs[9]  = '{4'b1011, 1'b0, d, 4'b0010, 2'd1, 16'h4567};
        vecs[10] = '{4'b1011, 1'b0, d, 4'b1000, 2'd3, 16'h89EF};
        vecs[11] = '{4'b1011, 1'b0, d, 4'b1000, 2'd3, 16'h89EF};
        vecs[12] = '{4'b1011, 1'b0, d, 4'b0001, 2'd0, 16'h0123};
        vecs[13] = '{4'b1011, 1'b0, d, 4'b0001, 2'd0, 16'h0123};
        vecs[14] = '{4'b1011, 1'b0, d, 4'b0010, 2'd1, 16'h4567};
        vecs[15] = '{4'b1011, 1'b1, d, 4'b0010, 2'd1, 16'h4567};
        vecs[16] = '{4'b1011, 1'b1, d, 4'b0010, 2'd1, 16'h4567};
        vecs[17] = '{4'b1011, 1'b1, d, 4'b0010, 2'd1, 16'h4567};

        // Reset, then idle for 64 cycles.
        rst = 1'b1; req = 4'b0000; lock = 1'b0; src_data = d;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_seg",   32'(seg),     32'h7F);
        check("rst_an",    32'(an),      32'hF);
        check("rst_dp",    32'(dp),      32'h1);
        check("rst_grant", 32'(grant),   32'h0);
        check("rst_cur",   32'(cur_src), 32'h0);
        rst = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            check("idle_an",    32'(an),    32'hF);
            check("idle_seg",   32'(seg),   32'h7F);
            check("idle_dp",    32'(dp),    32'h1);
            check("idle_grant", 32'(grant), 32'h0);
        end

        // Single source, rotation and lock, driven from the vector table.
        mon_start = 80;
        mon_en    = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wait_cyc(78 + 16 * i);
            req      = vecs[i].req;
            lock     = vecs[i].lock;
            src_data = vecs[i].data;
            push_show(vecs[i].exp_grant, vecs[i].exp_cur, vecs[i].exp_data);
        end

        // Owner 1 is locked in the frame starting at 352. Drop its request
        // and scribble its data during digit 2: the frame finishes from the
        // snapshot, then ownership moves on to source 3.
        wait_cyc(360);
        req             = 4'b1001;
        lock            = 1'b0;
        src_data[31:16] = 16'hFFFF;
        src_data[63:48] = 16'h1234;
        push_show(4'b1000, 2'd3, 16'h1234);

        // Change the owner's word during digit 1: the rest of the frame keeps
        // 1234, the next frame (same owner, second dwell frame) shows 5678.
        wait_cyc(373);
        src_data[63:48] = 16'h5678;
        push_show(4'b1000, 2'd3, 16'h5678);

        // Dwell expires: search from source 0 finds source 0.
        wait_cyc(390);
        push_show(4'b0001, 2'd0, 16'h0123);

        // Reset in the middle of digit 1 while showing.
        wait_cyc(406);
        mon_en = 1'b0;
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_seg",   32'(seg),     32'h7F);
        check("mid_rst_an",    32'(an),      32'hF);
        check("mid_rst_dp",    32'(dp),      32'h1);
        check("mid_rst_grant", 32'(grant),   32'h0);
        check("mid_rst_cur",   32'(cur_src), 32'h0);
        rst = 1'b0;

        // First frame after release: blank for 16 cycles, then search from
        // source 1 (cur_src reset to 0) lands on source 3.
        mon_start = 4;
        push_idle(2'd0);
        push_idle(2'd0);
        push_idle(2'd0);
        push_show(4'b1000, 2'd3, 16'h5678);
        mon_en = 1'b1;
        wait_cyc(30);
        push_show(4'b1000, 2'd3, 16'h5678);

        wait_cyc(46);
        check("sb_drain", 32'(sb.size()), 32'h0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
